// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
// Runs ROUNDS rounds. Each round waits GAP_TICKS ticks, raises one
// pseudo-random mole for up to UP_TICKS ticks and watches the eight hit
// buttons. A hit shows the hit mask for HIT_TICKS ticks. Hits and
// timeouts are counted with saturating counters.
// Ports:
//   CLK         system clock
//   RST_BTN     asynchronous active-high reset
//   start       level input; a rising edge starts a game from IDLE or DONE
//   btn[7:0]    conditioned hit buttons, bit i = hole i
//   random_num  one-hot mole-up mask, or 0
//   mole_hit    one-hot hit mask, or 0
//   score       hits this game, saturating
//   misses      timeouts this game, saturating
//   busy        high in GAP, UP and SHOW_HIT
//   game_over   high in DONE
module mole_scheduler #(
  parameter int         TICK_DIV  = 1_000_000,
  parameter int         GAP_TICKS = 50,
  parameter int         UP_TICKS  = 100,
  parameter int         HIT_TICKS = 25,
  parameter int         ROUNDS    = 30,
  parameter logic [7:0] LFSR_SEED = 8'hB8
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       start,
  input  logic [7:0] btn,
  output logic [7:0] random_num,
  output logic [7:0] mole_hit,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       busy,
  output logic       game_over
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMX0 = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
  localparam int TMAX = (TMX0 > HIT_TICKS) ? TMX0 : HIT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_SHOW_HIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      rnd_q, rnd_d;
  logic [7:0]      hit_q, hit_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      miss_q, miss_d;
  logic [7:0]      round_q, round_d;
  logic [2:0]      idx_q, idx_d;
  logic            start_q;
  logic [7:0]      btn_q;

  logic            start_re;
  logic [7:0]      btn_re;
  logic            tick;
  logic [TW-1:0]   lim;
  logic            timeout;
  logic [2:0]      pick;
  logic [7:0]      round_inc;
  logic            last_round;

  assign start_re = start & ~start_q;
  assign btn_re   = btn & ~btn_q;
  assign tick     = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    lim = '0;
    case (state_q)
      S_GAP:      lim = TW'(GAP_TICKS - 1);
      S_UP:       lim = TW'(UP_TICKS - 1);
      S_SHOW_HIT: lim = TW'(HIT_TICKS - 1);
      default:    lim = '0;
    endcase
  end

  assign timeout = tick && (tmr_q == lim);

  // Galois form of x^8+x^6+x^5+x^4+1 (right shift, feedback mask 0xB8).
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  // Never repeat the previous hole back to back.
  assign pick = (lfsr_q[2:0] == idx_q) ? 3'(lfsr_q[2:0] + 3'd1) : lfsr_q[2:0];

  assign round_inc  = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
  assign last_round = (round_inc == 8'(ROUNDS));

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    hit_d   = hit_q;
    score_d = score_q;
    miss_d  = miss_q;
    round_d = round_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_re) begin
          state_d = S_GAP;
          score_d = '0;
          miss_d  = '0;
          round_d = '0;
          rnd_d   = '0;
          hit_d   = '0;
        end
      end
      S_GAP: begin
        if (timeout) begin
          state_d = S_UP;
          idx_d   = pick;
          rnd_d   = 8'b1 << pick;
        end
      end
      S_UP: begin
        // Hit is checked first so it wins over a same-cycle timeout.
        if (btn_re[idx_q]) begin
          state_d = S_SHOW_HIT;
          rnd_d   = '0;
          hit_d   = 8'b1 << idx_q;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end else if (timeout) begin
          state_d = last_round ? S_DONE : S_GAP;
          rnd_d   = '0;
          miss_d  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
          round_d = round_inc;
        end
      end
      S_SHOW_HIT: begin
        if (timeout) begin
          state_d = last_round ? S_DONE : S_GAP;
          hit_d   = '0;
          round_d = round_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler and tick timer restart on every state change so each timed
  // state lasts exactly N*TICK_DIV clocks; they idle at zero otherwise.
  always_comb begin
    pre_d = pre_q;
    tmr_d = tmr_q;
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
      pre_d = '0;
      tmr_d = '0;
    end else if (tick) begin
      pre_d = '0;
      tmr_d = tmr_q + TW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tmr_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rnd_q   <= '0;
      hit_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      round_q <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tmr_q   <= tmr_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      start_q <= start;
      btn_q   <= btn;
    end
  end

  assign random_num = rnd_q;
  assign mole_hit   = hit_q;
  assign score      = score_q;
  assign misses     = miss_q;
  assign busy       = (state_q == S_GAP) || (state_q == S_UP) || (state_q == S_SHOW_HIT);
  assign game_over  = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with TICK_DIV=4, GAP_TICKS=2,
// UP_TICKS=5, HIT_TICKS=3, ROUNDS=3: GAP is 8 clocks, UP 20, SHOW_HIT 12.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] btn = '0;
  logic [7:0] random_num, mole_hit, score, misses;
  logic       busy, game_over;

  int total = 0;
  int bad   = 0;

  logic [7:0] m1, m2, m3;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV (4),
    .GAP_TICKS(2),
    .UP_TICKS (5),
    .HIT_TICKS(3),
    .ROUNDS   (3),
    .LFSR_SEED(8'hB8)
  ) dut (
    .CLK       (clk),
    .RST_BTN   (rst),
    .start     (start),
    .btn       (btn),
    .random_num(random_num),
    .mole_hit  (mole_hit),
    .score     (score),
    .misses    (misses),
    .busy      (busy),
    .game_over (game_over)
  );

  task automatic wait_mole(input string name, output logic [7:0] m);
    int n;
    n = 0;
    while (random_num === 8'h00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!$onehot(random_num)) begin
      bad++;
      $display("FAIL %s: random_num=%h required one-hot after %0d clk", name, random_num, n);
    end
    m = random_num;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({random_num, mole_hit, score, misses, busy, game_over} !== 34'h0) begin
      bad++;
      $display("FAIL reset_hold: outs=%h/%h/%h/%h/%b/%b required all 0",
               random_num, mole_hit, score, misses, busy, game_over);
    end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if ({random_num, mole_hit, score, misses, busy, game_over} !== 34'h0) begin
      bad++;
      $display("FAIL idle_100: outs=%h/%h/%h/%h/%b/%b required all 0",
               random_num, mole_hit, score, misses, busy, game_over);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || random_num !== 8'h00) begin
      bad++;
      $display("FAIL start_busy: busy=%b random_num=%h required 1/00", busy, random_num);
    end
    repeat (7) @(negedge clk);
    total++;
    if (random_num !== 8'h00) begin
      bad++;
      $display("FAIL gap_7clk: random_num=%h required 00", random_num);
    end
    @(negedge clk);
    total++;
    if (!$onehot(random_num)) begin
      bad++;
      $display("FAIL gap_8clk: random_num=%h required one-hot", random_num);
    end
    m1 = random_num;
  endtask

  task automatic test_hit();
    repeat (12) @(negedge clk);
    btn = m1;
    @(negedge clk);
    total++;
    if (random_num !== 8'h00 || mole_hit !== m1 || score !== 8'd1) begin
      bad++;
      $display("FAIL hit: rnd=%h hit=%h score=%0d required 00/%h/1", random_num, mole_hit, score, m1);
    end
    // start while busy must not restart the game
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (score !== 8'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_busy_ignored: score=%0d busy=%b required 1/1", score, busy);
    end
    repeat (10) @(negedge clk);
    total++;
    if (mole_hit !== m1) begin
      bad++;
      $display("FAIL hit_11clk: mole_hit=%h required %h", mole_hit, m1);
    end
    @(negedge clk);
    total++;
    if (mole_hit !== 8'h00 || busy !== 1'b1 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL hit_clear_12clk: mole_hit=%h busy=%b go=%b required 00/1/0", mole_hit, busy, game_over);
    end
    btn = '0;
  endtask

  task automatic test_hit_timeout_wrong();
    wait_mole("mole_r2", m2);
    total++;
    if (m2 === m1) begin
      bad++;
      $display("FAIL repeat_r2: mole=%h required differs from %h", m2, m1);
    end
    repeat (19) @(negedge clk);
    btn = m2 | {m2[6:0], m2[7]};
    @(negedge clk);
    total++;
    if (random_num !== 8'h00 || mole_hit !== m2 || score !== 8'd2 || misses !== 8'd0) begin
      bad++;
      $display("FAIL hit_vs_timeout: rnd=%h hit=%h score=%0d misses=%0d required 00/%h/2/0",
               random_num, mole_hit, score, misses, m2);
    end
    repeat (12) @(negedge clk);
    total++;
    if (mole_hit !== 8'h00) begin
      bad++;
      $display("FAIL hit2_clear: mole_hit=%h required 00", mole_hit);
    end
    btn = 8'hFF;
  endtask

  task automatic test_held_button();
    wait_mole("mole_r3", m3);
    total++;
    if (m3 === m2) begin
      bad++;
      $display("FAIL repeat_r3: mole=%h required differs from %h", m3, m2);
    end
    repeat (19) @(negedge clk);
    total++;
    if (random_num !== m3 || score !== 8'd2) begin
      bad++;
      $display("FAIL held_btn: rnd=%h score=%0d required %h/2", random_num, score, m3);
    end
    @(negedge clk);
    total++;
    if (random_num !== 8'h00 || misses !== 8'd1 || score !== 8'd2 ||
        game_over !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL game1_done: rnd=%h misses=%0d score=%0d go=%b busy=%b required 00/1/2/1/0",
               random_num, misses, score, game_over, busy);
    end
    btn = '0;
  endtask

  task automatic test_all_miss();
    logic [7:0] m, prev;
    prev = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (score !== 8'd0 || misses !== 8'd0 || busy !== 1'b1 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL restart: score=%0d misses=%0d busy=%b go=%b required 0/0/1/0",
               score, misses, busy, game_over);
    end
    for (int r = 0; r < 3; r++) begin
      wait_mole("mole_miss", m);
      if (r > 0) begin
        total++;
        if (m === prev) begin
          bad++;
          $display("FAIL repeat_miss: round=%0d mole=%h required differs from %h", r, m, prev);
        end
      end
      prev = m;
      repeat (20) @(negedge clk);
      total++;
      if (random_num !== 8'h00 || misses !== 8'(r + 1)) begin
        bad++;
        $display("FAIL miss_round: round=%0d rnd=%h misses=%0d required 00/%0d", r, random_num, misses, r + 1);
      end
    end
    total++;
    if (misses !== 8'd3 || score !== 8'd0 || game_over !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL all_miss_done: misses=%0d score=%0d go=%b busy=%b required 3/0/1/0",
               misses, score, game_over, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mole("mole_pre_rst", m);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({random_num, mole_hit, score, misses, busy, game_over} !== 34'h0) begin
      bad++;
      $display("FAIL async_reset: outs=%h/%h/%h/%h/%b/%b required all 0",
               random_num, mole_hit, score, misses, busy, game_over);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (random_num !== 8'h00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_gap: rnd=%h busy=%b required 00/1", random_num, busy);
    end
    @(negedge clk);
    total++;
    if (!$onehot(random_num) || score !== 8'd0 || misses !== 8'd0 || mole_hit !== 8'h00) begin
      bad++;
      $display("FAIL post_rst_game: rnd=%h score=%0d misses=%0d hit=%h required onehot/0/0/00",
               random_num, score, misses, mole_hit);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_hit();
    test_hit_timeout_wrong();
    test_held_button();
    test_all_miss();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
